// File: rtl/rmst_to_fifo_tile_strided.sv
// Strided 2-D tile loader: issues row-bounded bursts on the Avalon read master
// under an outstanding-word credit limit, then unpacks XDW-bit beats into
// DW-bit words for a downstream FIFO that signals almost-full.
`timescale 1ns/1ps
module rmst_to_fifo_tile_strided #(
  parameter int DW         = 32,
  parameter int XDW        = 128,
  parameter int XAW        = 32,
  parameter int CW         = 16,
  parameter int WCNT       = XDW / DW,
  parameter int BLEN       = 8,
  parameter int FIFO_CAP   = 64,
  parameter int LANE_ORDER = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [XAW-1:0] cfg_base_addr,
  input  logic [CW-1:0]  cfg_row_words,
  input  logic [CW-1:0]  cfg_rows,
  input  logic [XAW-1:0] cfg_row_stride,
  output logic           busy,
  output logic           done,
  output logic           cfg_err,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [CW-1:0]  rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           rmst_user_read_buffer,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  input  logic           rmst_user_data_available,
  output logic [DW-1:0]  out_data,
  output logic           out_push,
  input  logic           out_almost_full
);

  localparam int LW  = (WCNT > 1) ? $clog2(WCNT) : 1;
  localparam int CW1 = CW + 1;
  localparam logic [XAW-1:0] BPW_A  = XAW'(DW / 8);
  localparam logic [CW-1:0]  BPW_C  = CW'(DW / 8);
  localparam logic [CW-1:0]  BLEN_C = CW'(BLEN);
  localparam logic [CW-1:0]  WCNT_C = CW'(WCNT);
  localparam logic [CW:0]    CAP_C  = CW1'(FIFO_CAP);
  localparam logic [LW-1:0]  LAST_L = LW'(WCNT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           gap_q;
  logic           cfg_err_q;
  logic [XAW-1:0] row_addr_q, stride_q;
  logic [CW-1:0]  col_q, row_idx_q, rows_q, row_words_q, total_q;
  logic [CW-1:0]  issued_q, pushed_q;

  logic           full_q, live_q;
  logic [LW-1:0]  lane_q;
  logic [XDW-1:0] beat_q;

  logic [2*CW-1:0] prod;
  logic            cfg_bad, accept;
  logic [CW-1:0]   rem, bw, outstanding;
  logic            credit_ok, row_end;
  logic            push, pop, last_lane;
  logic [LW-1:0]   sel;

  assign prod        = {{CW{1'b0}}, cfg_row_words} * {{CW{1'b0}}, cfg_rows};
  assign cfg_bad     = (cfg_row_words == '0) || (cfg_rows == '0) ||
                       ((cfg_row_words % WCNT_C) != '0) || (prod[2*CW-1:CW] != '0);
  assign accept      = (state_q == IDLE) && start && !cfg_bad;
  assign rem         = row_words_q - col_q;
  assign bw          = (rem > BLEN_C) ? BLEN_C : rem;
  assign outstanding = issued_q - pushed_q;
  assign credit_ok   = ({1'b0, outstanding} + {1'b0, bw}) <= CAP_C;
  assign row_end     = (col_q + bw) == row_words_q;

  // Burst sequencing: issue under credit, wait out the GAP, then drain pushes
  always_comb begin
    state_d          = state_q;
    rmst_go          = 1'b0;
    rmst_read_base   = '0;
    rmst_read_length = '0;
    done             = 1'b0;
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        rmst_read_base   = row_addr_q + XAW'(col_q) * BPW_A;
        rmst_read_length = bw * BPW_C;
        if (rmst_done && credit_ok) begin
          rmst_go = 1'b1;
          state_d = GAP;
        end
      end
      GAP:   if (gap_q) state_d = (row_idx_q != rows_q) ? ISSUE : DRAIN;
      DRAIN: if (pushed_q == total_q) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, tile geometry, address walk and word counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gap_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      row_addr_q  <= '0;
      stride_q    <= '0;
      col_q       <= '0;
      row_idx_q   <= '0;
      rows_q      <= '0;
      row_words_q <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      pushed_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == GAP) ? ~gap_q : 1'b0;
      if (state_q == IDLE && start && cfg_bad) cfg_err_q <= 1'b1;
      if (accept) begin
        cfg_err_q   <= 1'b0;
        row_addr_q  <= cfg_base_addr;
        stride_q    <= cfg_row_stride;
        row_words_q <= cfg_row_words;
        rows_q      <= cfg_rows;
        total_q     <= prod[CW-1:0];
        col_q       <= '0;
        row_idx_q   <= '0;
        issued_q    <= '0;
        pushed_q    <= '0;
      end else if (push) begin
        pushed_q <= pushed_q + 1'b1;
      end
      if (rmst_go) begin
        issued_q <= issued_q + bw;
        if (row_end) begin
          col_q      <= '0;
          row_addr_q <= row_addr_q + stride_q;
          row_idx_q  <= row_idx_q + 1'b1;
        end else begin
          col_q <= col_q + bw;
        end
      end
    end
  end

  // Unpacker: the last lane's push and the next beat's pop share a cycle so
  // beats stream without a bubble; live_q keeps pops off while in reset.
  assign push      = full_q && !out_almost_full;
  assign last_lane = (lane_q == LAST_L);
  assign pop       = live_q && rmst_user_data_available && (!full_q || (push && last_lane));
  assign sel       = (LANE_ORDER != 0) ? (LAST_L - lane_q) : lane_q;

  // Holder occupancy and lane pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q <= 1'b0;
      full_q <= 1'b0;
      lane_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (pop) begin
        full_q <= 1'b1;
        lane_q <= '0;
      end else if (push) begin
        if (last_lane) begin
          full_q <= 1'b0;
          lane_q <= '0;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  // Beat holder data, captured on pop
  always_ff @(posedge clk) begin
    if (pop) beat_q <= rmst_user_buffer_data;
  end

  assign out_data              = full_q ? beat_q[sel*DW +: DW] : '0;
  assign out_push              = push;
  assign rmst_user_read_buffer = pop;
  assign busy                  = (state_q != IDLE);
  assign cfg_err               = cfg_err_q;
  assign rmst_fixed_location   = 1'b0;

endmodule

// File: doc/rmst_to_fifo_tile_strided.md
Name: rmst_to_fifo_tile_strided

Overview:
Generalised read-master tile loader. Fetches a 2-D tile of cfg_rows rows × cfg_row_words words, row pitch cfg_row_stride bytes, through the Avalon read master, and unpacks XDW-bit beats into DW-bit words pushed into a downstream FIFO. Adds over the previous loader:
- strided multi-row tiles;
- generic lane count;
- selectable lane order;
- credit-based outstanding-read limit;
- downstream almost-full backpressure on the unpacker;
- config error reporting.
Sits between the read master and the in/out feature-map load FIFOs.

Parameters:
DW, 32, output word width
XDW, 128, read-master beat width; must be an integer multiple of DW
XAW, 32, byte address width
CW, 16, length/counter width
WCNT, XDW/DW, lanes per beat (≥1)
BLEN, 8, maximum words per rmst_go burst; multiple of WCNT
FIFO_CAP, 64, words the read-master FIFO can hold; max outstanding words
LANE_ORDER, 0, 0: lane 0 (bits DW-1:0) pushed first; 1: top lane pushed first

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches cfg_*
cfg_base_addr  in  XAW  byte address of tile row 0
cfg_row_words  in  CW  words per row
cfg_rows  in  CW  rows in tile
cfg_row_stride  in  XAW  byte distance between row starts
busy  out  1  tile in progress
done  out  1  one-cycle pulse at tile completion
cfg_err  out  1  sticky; set on rejected start
rmst_fixed_location  out  1  tied 0
rmst_read_base  out  XAW  burst byte address
rmst_read_length  out  CW  burst length in bytes
rmst_go  out  1  one-cycle burst request
rmst_done  in  1  master idle
rmst_user_read_buffer  out  1  pop one beat (show-ahead FIFO)
rmst_user_buffer_data  in  XDW  head beat, valid while data_available
rmst_user_data_available  in  1  beat present
out_data  out  DW  word to downstream FIFO
out_push  out  1  word valid this cycle
out_almost_full  in  1  downstream cannot accept a push next cycle

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM IDLE; all counters 0; cfg_err 0.
- start in IDLE:
  - Rejected (cfg_err←1, stay IDLE, no done) if cfg_row_words==0, cfg_rows==0, or cfg_row_words%WCNT≠0.
  - Otherwise latch cfg_*, clear cfg_err, busy←1, go to ISSUE.
- start while busy is ignored.
- FSM states: IDLE → ISSUE ↔ GAP → DRAIN → IDLE.
- ISSUE:
  - Burst words bw = min(BLEN, remaining words in current row).
  - rmst_go=1 for one cycle when all hold: rmst_done=1 AND outstanding+bw ≤ FIFO_CAP.
  - outstanding = issued_words − pushed_words (CW bits).
  - Same cycle: rmst_read_base = row_addr + col_words·(DW/8); rmst_read_length = bw·(DW/8).
  - Then go to GAP.
- GAP:
  - Holds 2 cycles (the master's rmst_done is not trustworthy immediately after go).
  - Exit to ISSUE if words remain, else DRAIN.
- Address advance: after the last burst of a row, row_addr += cfg_row_stride and col resets to 0. Bursts never cross a row.
- Unpacker (runs independently of the FSM):
  - Holds one beat plus a lane index.
  - rmst_user_read_buffer=1 when data_available=1 AND (holder empty OR (last lane pushing this cycle)).
  - The beat is captured that same cycle.
  - out_push=1 each cycle the holder is non-empty and out_almost_full=0.
  - out_data = the current lane selected per LANE_ORDER; lane index advances on each push.
  - Sustained rate: one word/clk; beats back-to-back with no bubble.
  - out_almost_full=1 freezes the lane and blocks pops; no word lost or duplicated.
- DRAIN: when pushed_words == cfg_row_words·cfg_rows, done=1 for one cycle, busy←0, go to IDLE (done coincides with busy falling).
- Latency: first out_push exactly 1 cycle after the first rmst_user_read_buffer.
- Counters pushed_words/issued_words are CW bits. A tile exceeding 2^CW−1 words is rejected via cfg_err.
- Simultaneous pop and push: permitted in one cycle; the holder is refilled without a gap.
- Reset mid-tile: abandons immediately. Stale beats in the master FIFO are the system's responsibility.

Test Plan:
- Single row: row_words=16, rows=1, base=0x1000, XDW=128 → two rmst_go, base 0x1000/0x1020, length 32 each; 16 pushes of words 0..15 in order; done 1 cycle after the 16th push.
- Strided tile: row_words=12, rows=3, stride=0x400, base=0 → bursts (0x000,32),(0x020,16),(0x400,32),(0x420,16),(0x800,32),(0x820,16); 36 pushes.
- Credit limit: FIFO_CAP=16, hold data_available=0 → exactly 2 rmst_go issued, no third until ≥8 words pushed.
- Backpressure: assert out_almost_full for 5 cycles mid-beat → out_push=0 those cycles; output sequence identical to unstalled run.
- LANE_ORDER=1, beat 0x00000003_00000002_00000001_00000000 → pushes 3,2,1,0.
- row_words=6 with WCNT=4 → cfg_err=1, no rmst_go, busy stays 0. Then rst low for 1 cycle mid-tile → all outputs 0 asynchronously.
